// File: rtl/mips_datapath_alu_muldiv.sv
// Multi-cycle multiply/divide unit beside the execute-stage ALU; owns HI/LO.
// Shift-add multiply and restoring divide on magnitudes, with the sign applied in a final FIX cycle.
package mips_datapath_alu_muldiv_pkg;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } Data_Control_Control_T;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;
endpackage

module mips_datapath_alu_muldiv
  import mips_datapath_alu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  Data_Control_Control_T ctrl,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_W-1:0]     data1,
  input  logic [DATA_W-1:0]     data2,
  input  logic                  rd_req,
  output logic                  stall,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  logic                  clk;
  logic                  rst_n;
  md_op_e                op;
  state_e                state, state_nxt;
  logic                  accept;
  logic                  sgn_op;
  logic                  last;
  logic [DATA_W-1:0]     mag_a, mag_b;
  logic [2*DATA_W-1:0]   prod;
  logic [DATA_W-1:0]     opnd;
  logic [CNT_W-1:0]      cnt;
  logic                  neg_res, neg_rem, div_op;
  logic [DATA_W:0]       mul_sum;
  logic [DATA_W:0]       div_trial;
  logic [2*DATA_W-1:0]   div_step;

  assign clk   = ctrl.clk;
  assign rst_n = ctrl.rst_n;
  assign op    = md_op_e'(req_op);

  always_comb begin
    req_ready = (state == S_IDLE);
    stall     = rd_req && (state != S_IDLE);
    accept    = req_valid && req_ready && !flush &&
                (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO});
    sgn_op    = (op == OP_MULT) || (op == OP_DIV);
    mag_a     = (sgn_op && data1[DATA_W-1]) ? -data1 : data1;
    mag_b     = (sgn_op && data2[DATA_W-1]) ? -data2 : data2;
    last      = (cnt == CNT_W'(DATA_W - 1));
  end

  // prod holds {partial product, remaining multiplier} in MUL and {remainder, dividend/quotient} in DIV.
  always_comb begin
    mul_sum   = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, opnd} : '0);
    div_trial = {prod[2*DATA_W-1:DATA_W], prod[DATA_W-1]} - {1'b0, opnd};
    div_step  = div_trial[DATA_W] ? {prod[2*DATA_W-2:0], 1'b0}
                                  : {div_trial[DATA_W-1:0], prod[DATA_W-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: state_nxt = S_MUL;
              OP_DIV, OP_DIVU:   state_nxt = (data2 == '0) ? S_FIX : S_DIV;
              default:           state_nxt = S_IDLE;
            endcase
          end
        end
        S_MUL, S_DIV: if (last) state_nxt = S_FIX;
        S_FIX:        state_nxt = S_IDLE;
        default:      state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      prod    <= '0;
      opnd    <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div_op  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt     <= '0;
            opnd    <= mag_b;
            neg_res <= sgn_op && (data1[DATA_W-1] ^ data2[DATA_W-1]);
            neg_rem <= sgn_op && data1[DATA_W-1];
            case (op)
              OP_MTHI: begin
                hi   <= data1;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= data1;
                done <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
                div_op <= 1'b0;
                prod   <= {{DATA_W{1'b0}}, mag_a};
              end
              default: begin
                // Zero divisor: preload the final remainder/quotient so FIX only applies signs.
                div_op <= 1'b1;
                prod   <= (data2 == '0) ? {mag_a, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, mag_a};
              end
            endcase
          end
        end
        S_MUL: begin
          prod <= {mul_sum, prod[DATA_W-1:1]};
          cnt  <= cnt + 1'b1;
        end
        S_DIV: begin
          prod <= div_step;
          cnt  <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!flush) begin
            if (div_op) begin
              lo <= neg_res ? -prod[DATA_W-1:0] : prod[DATA_W-1:0];
              hi <= neg_rem ? -prod[2*DATA_W-1:DATA_W] : prod[2*DATA_W-1:DATA_W];
            end else begin
              {hi, lo} <= neg_res ? -prod : prod;
            end
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
